forward_hazard_unit: RTL and testbench
======================================

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameter: REG_AW, default 5, register-address width.
REQ-002 Parameter: CNT_W, default 16, stall-counter width.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk_i  input  1  rising-edge clock.
REQ-005 rst_i  input  1  asynchronous active-low reset.
REQ-006 id_valid_i  input  1  ID stage holds a real instruction.
REQ-007 id_rs_i  input  REG_AW  ID source register A.
REQ-008 id_rt_i  input  REG_AW  ID source register B.
REQ-009 id_rt_used_i  input  1  ID instruction reads rt as an operand.
REQ-010 id_rd_i  input  REG_AW  ID destination register, already resolved from rt/rd.
REQ-011 id_regwrite_i  input  1  ID instruction writes the register file.
REQ-012 id_memread_i  input  1  ID instruction is a load.
REQ-013 flush_i  input  1  taken branch; kill the ID instruction.
REQ-014 forward_a_o  output  2  select for the EX operand-A 3-to-1 mux.
REQ-015 forward_b_o  output  2  select for the EX operand-B 3-to-1 mux.
REQ-016 stall_o  output  1  hold PC and IF/ID; insert bubble.
REQ-017 stall_cnt_o  output  CNT_W  count of stall cycles.

Function
REQ-018 The block SHALL keep three tracking records, updated every rising edge:
- EX: rs, rt, rd, regwrite, memread.
- MEM: rd, regwrite, memread.
- WB: rd, regwrite.
REQ-019 Each edge, WB SHALL load from MEM, MEM from EX, and EX from the ID inputs.
REQ-020 EX SHALL load a bubble instead when stall_o=1, flush_i=1, or id_valid_i=0; a bubble is all fields 0.
REQ-021 Select encoding SHALL be: 0 = ID/EX register value, 1 = EX/MEM result, 2 = MEM/WB result; value 3 is never driven.
REQ-022 forward_a_o SHALL be combinational from the records:
- 1 if MEM.regwrite && MEM.rd!=0 && MEM.rd==EX.rs;
- else 2 if WB.regwrite && WB.rd!=0 && WB.rd==EX.rs;
- else 0.
REQ-023 forward_b_o SHALL apply the same rule using EX.rt.
REQ-024 When MEM and WB both match, MEM (value 1) SHALL take priority.
REQ-025 Register 0 SHALL never cause forwarding or a stall.
REQ-026 stall_o SHALL be combinational and equal to 1 when all of the following hold:
- EX.memread && EX.regwrite && EX.rd!=0;
- id_valid_i && !flush_i;
- EX.rd==id_rs_i, or (id_rt_used_i && EX.rd==id_rt_i).
REQ-027 A load-use stall SHALL last exactly one cycle.
- The next edge moves the load to MEM and puts a bubble in EX.
- The held ID instruction then sees forward select 2 from WB one cycle later.
REQ-028 flush_i=1 together with a stall condition SHALL give stall_o=0 and a bubble in EX.
REQ-029 stall_cnt_o SHALL increment by 1 on each edge where stall_o=1, and SHALL saturate at all-ones without wrapping.
REQ-030 Register-file write-before-read in the same cycle is outside this block; WB-to-ID bypass SHALL NOT be generated.

Reset
REQ-031 While rst_i=0, all records SHALL be cleared to bubble immediately, independent of clk_i.
REQ-032 Consequently, during reset forward_a_o=0, forward_b_o=0, stall_o=0 and stall_cnt_o=0.
REQ-033 Reset asserted mid-stall SHALL drop stall_o to 0 at once.
REQ-034 The first edge after rst_i rises SHALL load EX normally from the ID inputs.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- ALU chain, add $3 then sub $5,$3,$4 next cycle -> when sub is in EX, forward_a_o=1, forward_b_o=0, stall_o=0.
- One-gap chain, add $3; nop; or $6,$1,$3 -> forward_b_o=2 when or is in EX.
- Double match, $3 written in both MEM and WB, EX.rs=3 -> forward_a_o=1.
- Load-use, lw $2 then add $4,$2,$2 -> stall_o=1 for one cycle, stall_cnt_o 0->1; next cycle EX is a bubble; add then reaches EX with forward_a_o=2 and forward_b_o=2.
- Load to $0, lw $0 then add $4,$0,$1 -> stall_o=0, all forward selects 0.
- Flush during stall condition, flush_i=1 -> stall_o=0, EX bubble, stall_cnt_o unchanged.
- Reset mid-stall, rst_i=0 -> stall_o=0 and stall_cnt_o=0 immediately.
- Saturation, CNT_W=2 with 5 stall cycles -> stall_cnt_o=3.

Source files
------------

// File: rtl/forward_hazard_unit.sv
// Forwarding and load-use hazard unit for a classic 5-stage pipeline.
// Shadows the register fields of the EX, MEM and WB stages, drives the
// EX operand mux selects and detects load-use stalls.
module forward_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rt_used_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        forward_a_o,
  output logic [1:0]        forward_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [1:0] SelIdEx  = 2'd0;
  localparam logic [1:0] SelExMem = 2'd1;
  localparam logic [1:0] SelMemWb = 2'd2;

  // EX stage record
  logic [REG_AW-1:0] ex_rs_q, ex_rt_q, ex_rd_q;
  logic              ex_regwrite_q, ex_memread_q;
  logic [REG_AW-1:0] ex_rs_d, ex_rt_d, ex_rd_d;
  logic              ex_regwrite_d, ex_memread_d;

  // MEM and WB stage records (a load in MEM or WB forwards like any other
  // write, so their memread flag is not needed here)
  logic [REG_AW-1:0] mem_rd_q, wb_rd_q;
  logic              mem_regwrite_q, wb_regwrite_q;

  logic [CNT_W-1:0]  stall_cnt_q;

  logic loadInEx, idReadsLoad;
  logic memHitA, wbHitA, memHitB, wbHitB;

  // Load-use detection: a load sitting in EX whose result the ID instruction needs
  always_comb begin
    loadInEx    = ex_memread_q && ex_regwrite_q && (ex_rd_q != '0);
    idReadsLoad = (ex_rd_q == id_rs_i) || (id_rt_used_i && (ex_rd_q == id_rt_i));
    stall_o     = loadInEx && id_valid_i && !flush_i && idReadsLoad;
  end

  // Forward selects; the younger MEM producer wins over WB, $0 never forwards
  always_comb begin
    memHitA = mem_regwrite_q && (mem_rd_q != '0) && (mem_rd_q == ex_rs_q);
    wbHitA  = wb_regwrite_q  && (wb_rd_q  != '0) && (wb_rd_q  == ex_rs_q);
    memHitB = mem_regwrite_q && (mem_rd_q != '0) && (mem_rd_q == ex_rt_q);
    wbHitB  = wb_regwrite_q  && (wb_rd_q  != '0) && (wb_rd_q  == ex_rt_q);
    forward_a_o = memHitA ? SelExMem : (wbHitA ? SelMemWb : SelIdEx);
    forward_b_o = memHitB ? SelExMem : (wbHitB ? SelMemWb : SelIdEx);
  end

  // Next EX record: a bubble whenever the ID instruction must not advance
  always_comb begin
    ex_rs_d       = '0;
    ex_rt_d       = '0;
    ex_rd_d       = '0;
    ex_regwrite_d = 1'b0;
    ex_memread_d  = 1'b0;
    if (id_valid_i && !flush_i && !stall_o) begin
      ex_rs_d       = id_rs_i;
      ex_rt_d       = id_rt_i;
      ex_rd_d       = id_rd_i;
      ex_regwrite_d = id_regwrite_i;
      ex_memread_d  = id_memread_i;
    end
  end

  // Advance the stage records one step down the pipeline each cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_rd_q        <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_rd_q       <= '0;
      mem_regwrite_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_regwrite_q  <= 1'b0;
    end else begin
      wb_rd_q        <= mem_rd_q;
      wb_regwrite_q  <= mem_regwrite_q;
      mem_rd_q       <= ex_rd_q;
      mem_regwrite_q <= ex_regwrite_q;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_rd_q        <= ex_rd_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Testbench for forward_hazard_unit: directed instruction sequences checked
// against a stage-list model every cycle, plus hand-computed expectations.
module tb_forward_hazard_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
  logic        id_rt_used_i, id_regwrite_i, id_memread_i, flush_i;
  logic [1:0]  forward_a_o, forward_b_o;
  logic        stall_o;
  logic [15:0] stall_cnt_o;
  logic [1:0]  smallFa, smallFb;
  logic        smallStall;
  logic [1:0]  smallCnt;

  int nCompared = 0;
  int nFailed   = 0;
  bit cmpOn     = 1'b0;

  always #5 clk_i = ~clk_i;

  forward_hazard_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rt_used_i(id_rt_used_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .flush_i(flush_i),
    .forward_a_o(forward_a_o), .forward_b_o(forward_b_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  forward_hazard_unit #(.REG_AW(5), .CNT_W(2)) dutSmall (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rt_used_i(id_rt_used_i),
    .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .flush_i(flush_i),
    .forward_a_o(smallFa), .forward_b_o(smallFb),
    .stall_o(smallStall), .stall_cnt_o(smallCnt)
  );

  // Model: list of in-flight instructions, index = distance past ID
  // (0 = EX, 1 = MEM, 2 = WB); the forward select equals the index of the
  // nearest older writer of the source register.
  typedef struct packed {
    logic [4:0] rs, rt, rd;
    logic       rw, mr;
  } rec_t;

  rec_t pipe [3];
  int   mStalls;

  function automatic logic [1:0] modelSel(input logic [4:0] src);
    for (int s = 1; s <= 2; s++)
      if (pipe[s].rw && pipe[s].rd != 5'd0 && pipe[s].rd == src) return 2'(s);
    return 2'd0;
  endfunction

  function automatic logic modelStall();
    if (!(pipe[0].mr && pipe[0].rw && pipe[0].rd != 5'd0)) return 1'b0;
    if (!id_valid_i || flush_i) return 1'b0;
    return (pipe[0].rd == id_rs_i) || (id_rt_used_i && pipe[0].rd == id_rt_i);
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      mStalls = 0;
    end else begin
      logic st;
      st = modelStall();
      if (st) mStalls++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (st || flush_i || !id_valid_i) pipe[0] = '0;
      else pipe[0] = '{id_rs_i, id_rt_i, id_rd_i, id_regwrite_i, id_memread_i};
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nCompared++;
    if (actual != expected) begin
      nFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk_i) begin
    if (cmpOn) begin
      checkOutput("model_fwd_a", forward_a_o, modelSel(pipe[0].rs));
      checkOutput("model_fwd_b", forward_b_o, modelSel(pipe[0].rt));
      checkOutput("model_stall", stall_o, modelStall());
      checkOutput("model_cnt", stall_cnt_o, (mStalls > 65535) ? 65535 : mStalls);
      checkOutput("model_small_fwd_a", smallFa, modelSel(pipe[0].rs));
      checkOutput("model_small_fwd_b", smallFb, modelSel(pipe[0].rt));
      checkOutput("model_small_stall", smallStall, modelStall());
      checkOutput("model_small_cnt", smallCnt, (mStalls > 3) ? 3 : mStalls);
    end
  end

  task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic used, input logic [4:0] rd, input logic rw,
                               input logic mr, input logic fl);
    @(posedge clk_i);
    #1;
    id_valid_i = v; id_rs_i = rs; id_rt_i = rt; id_rt_used_i = used;
    id_rd_i = rd; id_regwrite_i = rw; id_memread_i = mr; flush_i = fl;
  endtask

  task automatic issueAlu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    applyStimulus(1'b1, rs, rt, 1'b1, rd, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic issueLoad(input logic [4:0] rd, input logic [4:0] rs);
    applyStimulus(1'b1, rs, rd, 1'b0, rd, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic issueNop();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clearInputs();
    id_valid_i = 1'b0; id_rs_i = '0; id_rt_i = '0; id_rt_used_i = 1'b0;
    id_rd_i = '0; id_regwrite_i = 1'b0; id_memread_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0;
    clearInputs();
    #1;
    checkOutput("reset_fwd_a", forward_a_o, 0);
    checkOutput("reset_fwd_b", forward_b_o, 0);
    checkOutput("reset_stall", stall_o, 0);
    checkOutput("reset_cnt", stall_cnt_o, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    cmpOn = 1'b1;

    // ALU chain: add $3,$1,$2 ; sub $5,$3,$4
    issueAlu(5'd3, 5'd1, 5'd2);
    issueAlu(5'd5, 5'd3, 5'd4);
    issueNop();
    @(negedge clk_i);
    checkOutput("alu_fwd_a", forward_a_o, 1);
    checkOutput("alu_fwd_b", forward_b_o, 0);
    checkOutput("alu_stall", stall_o, 0);

    // One-gap chain: add $3 ; nop ; or $6,$1,$3
    issueAlu(5'd3, 5'd1, 5'd2);
    issueNop();
    issueAlu(5'd6, 5'd1, 5'd3);
    issueNop();
    @(negedge clk_i);
    checkOutput("gap_fwd_b", forward_b_o, 2);
    checkOutput("gap_fwd_a", forward_a_o, 0);

    // Double match: $3 written by both MEM and WB producers
    issueAlu(5'd3, 5'd1, 5'd2);
    issueAlu(5'd3, 5'd1, 5'd2);
    issueAlu(5'd7, 5'd3, 5'd0);
    issueNop();
    @(negedge clk_i);
    checkOutput("double_fwd_a", forward_a_o, 1);

    // Load-use: lw $2 ; add $4,$2,$2 (held one cycle by the stall)
    issueLoad(5'd2, 5'd1);
    issueAlu(5'd4, 5'd2, 5'd2);
    @(negedge clk_i);
    checkOutput("ldu_stall", stall_o, 1);
    checkOutput("ldu_cnt_before", stall_cnt_o, 0);
    issueAlu(5'd4, 5'd2, 5'd2);
    @(negedge clk_i);
    checkOutput("ldu_stall_after", stall_o, 0);
    checkOutput("ldu_cnt_after", stall_cnt_o, 1);
    checkOutput("ldu_bubble_fwd_a", forward_a_o, 0);
    issueNop();
    @(negedge clk_i);
    checkOutput("ldu_fwd_a", forward_a_o, 2);
    checkOutput("ldu_fwd_b", forward_b_o, 2);

    // Load to $0 never stalls or forwards
    issueLoad(5'd0, 5'd1);
    issueAlu(5'd4, 5'd0, 5'd1);
    @(negedge clk_i);
    checkOutput("zero_stall", stall_o, 0);
    issueNop();
    @(negedge clk_i);
    checkOutput("zero_fwd_a", forward_a_o, 0);
    checkOutput("zero_fwd_b", forward_b_o, 0);

    // Flush on top of a load-use condition
    issueLoad(5'd2, 5'd1);
    applyStimulus(1'b1, 5'd2, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);
    @(negedge clk_i);
    checkOutput("flush_stall", stall_o, 0);
    checkOutput("flush_cnt", stall_cnt_o, 1);
    issueNop();
    @(negedge clk_i);
    checkOutput("flush_ex_bubble_fwd_a", forward_a_o, 0);
    checkOutput("flush_cnt_after", stall_cnt_o, 1);

    // Reset asserted in the middle of a stall
    issueLoad(5'd2, 5'd1);
    issueAlu(5'd4, 5'd2, 5'd2);
    @(negedge clk_i);
    checkOutput("rst_pre_stall", stall_o, 1);
    #2;
    rst_i = 1'b0;
    clearInputs();
    #1;
    checkOutput("rst_mid_stall", stall_o, 0);
    checkOutput("rst_mid_cnt", stall_cnt_o, 0);
    checkOutput("rst_mid_small_cnt", smallCnt, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Saturation: five load-use stalls
    for (int i = 0; i < 5; i++) begin
      issueLoad(5'd2, 5'd1);
      issueAlu(5'd4, 5'd2, 5'd2);
    end
    issueNop();
    @(negedge clk_i);
    checkOutput("sat_small_cnt", smallCnt, 3);
    checkOutput("sat_big_cnt", stall_cnt_o, 5);

    issueNop();
    @(negedge clk_i);
    cmpOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
